// File: rtl/instruction_mmu.sv
// Instruction fetch responder: accepts word fetches, reads a fixed-latency BRAM and returns words in order.
// Optional fault checking for misaligned / out-of-range addresses is enabled by defining INSTRUCTION_MMU_FAULT_EN.
module instruction_mmu #(
    parameter int BRAM_DEPTH   = 4096,
    parameter int BRAM_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          flush_in,
    output logic                          request_ready_out,
    input  logic                          request_valid_in,
    input  logic [31:0]                   request_address_in,
    input  logic                          response_ready_in,
    output logic                          response_valid_out,
    output logic [31:0]                   response_data_out,
    output logic                          response_fault_out,
    output logic                          bram_en_out,
    output logic [$clog2(BRAM_DEPTH)-1:0] bram_addr_out,
    input  logic [31:0]                   bram_data_in
);

    localparam int AW = $clog2(BRAM_DEPTH);
    localparam int IW = $clog2(FIFO_DEPTH);
    localparam int PW = IW + 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH);
    localparam logic [31:0]   NOP_WORD   = 32'h0000_0013;

    // Handshake rule for both ports: a transfer happens in a cycle where valid and ready are
    // both high at the rising edge; ready on the request side never looks at response_ready_in.

    logic [CW-1:0]           r_outstanding;
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [BRAM_LATENCY-1:0] r_pipe_valid;
    logic [31:0]             r_fifo_data [FIFO_DEPTH];

    logic          w_accept;
    logic          w_pop;
    logic          w_empty;
    logic          w_req_fault;
    logic          w_last_valid;
    logic [31:0]   w_wr_data;
    logic [AW-1:0] w_index;

    assign w_index           = request_address_in[AW+1:2];
    assign request_ready_out = rst_in && (r_outstanding < CREDIT_MAX) && !flush_in;
    assign w_accept          = request_ready_out && request_valid_in;
    assign w_empty           = (r_wr_ptr == r_rd_ptr);
    assign response_valid_out = !w_empty;
    assign w_pop             = response_valid_out && response_ready_in;
    assign bram_en_out       = w_accept && !w_req_fault;
    assign bram_addr_out     = w_accept ? w_index : '0;
    assign w_last_valid      = r_pipe_valid[BRAM_LATENCY-1];
    assign response_data_out = w_empty ? 32'h0 : r_fifo_data[r_rd_ptr[IW-1:0]];

`ifdef INSTRUCTION_MMU_FAULT_EN
    logic [BRAM_LATENCY-1:0] r_pipe_fault;
    logic                    r_fifo_fault [FIFO_DEPTH];

    assign w_req_fault = (request_address_in[1:0] != 2'b00) ||
                         (request_address_in[31:AW+2] != '0);
    // A faulted slot never read the BRAM, so its payload is replaced by a NOP.
    assign w_wr_data          = r_pipe_fault[BRAM_LATENCY-1] ? NOP_WORD : bram_data_in;
    assign response_fault_out = !w_empty && r_fifo_fault[r_rd_ptr[IW-1:0]];

    always_ff @(posedge clk_in) begin
        r_pipe_fault[0] <= w_req_fault;
        for (int i = 1; i < BRAM_LATENCY; i++) begin
            r_pipe_fault[i] <= r_pipe_fault[i-1];
        end
        if (w_last_valid) begin
            r_fifo_fault[r_wr_ptr[IW-1:0]] <= r_pipe_fault[BRAM_LATENCY-1];
        end
    end
`else
    logic w_unused_addr;

    assign w_req_fault        = 1'b0;
    assign w_wr_data          = bram_data_in;
    assign response_fault_out = 1'b0;
    assign w_unused_addr      = &{1'b0, request_address_in[31:AW+2], request_address_in[1:0],
                                  NOP_WORD};
`endif

    // Tag pipeline tracks which BRAM read slots carry a live request; it never stalls.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_pipe_valid <= '0;
        end else if (flush_in) begin
            r_pipe_valid <= '0;
        end else begin
            r_pipe_valid[0] <= w_accept;
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_outstanding <= '0;
        end else if (flush_in) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_last_valid) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Credits guarantee a free entry whenever the last pipeline stage delivers.
    always_ff @(posedge clk_in) begin
        if (w_last_valid) begin
            r_fifo_data[r_wr_ptr[IW-1:0]] <= w_wr_data;
        end
    end

endmodule

// File: tb/tb_instruction_mmu.sv
// Directed bench for instruction_mmu with a one-cycle-latency BRAM model.
// The fault-response step is compiled only when INSTRUCTION_MMU_FAULT_EN is defined.
module tb_instruction_mmu;

    localparam int BRAM_DEPTH = 4096;
    localparam int AW         = $clog2(BRAM_DEPTH);

    logic          clk_in;
    logic          rst_in;
    logic          flush_in;
    logic          request_ready_out;
    logic          request_valid_in;
    logic [31:0]   request_address_in;
    logic          response_ready_in;
    logic          response_valid_out;
    logic [31:0]   response_data_out;
    logic          response_fault_out;
    logic          bram_en_out;
    logic [AW-1:0] bram_addr_out;
    logic [31:0]   bram_data_in;

    logic [31:0] bram_mem [BRAM_DEPTH];
    int          n_vectors;
    int          n_miscompares;
    logic [31:0] t2_exp [5];

    instruction_mmu #(
        .BRAM_DEPTH  (BRAM_DEPTH),
        .BRAM_LATENCY(1),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .flush_in          (flush_in),
        .request_ready_out (request_ready_out),
        .request_valid_in  (request_valid_in),
        .request_address_in(request_address_in),
        .response_ready_in (response_ready_in),
        .response_valid_out(response_valid_out),
        .response_data_out (response_data_out),
        .response_fault_out(response_fault_out),
        .bram_en_out       (bram_en_out),
        .bram_addr_out     (bram_addr_out),
        .bram_data_in      (bram_data_in)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    always @(posedge clk_in) begin
        if (bram_en_out) begin
            bram_data_in <= bram_mem[bram_addr_out];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        assert (obs === exp) else begin
            n_miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are checked 1 time unit later.
    task automatic drive(input logic v, input logic [31:0] a, input logic rr, input logic fl);
        @(negedge clk_in);
        request_valid_in   = v;
        request_address_in = a;
        response_ready_in  = rr;
        flush_in           = fl;
        #1;
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        for (int i = 0; i < BRAM_DEPTH; i++) begin
            bram_mem[i] = {16'hC0DE, 16'(i)};
        end
        bram_mem[4] = 32'hDEAD_BEEF;
        t2_exp = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, 32'hDEAD_BEEF};
        bram_data_in       = 32'h0;
        rst_in             = 1'b1;
        flush_in           = 1'b0;
        request_valid_in   = 1'b1;
        request_address_in = 32'h0000_0010;
        response_ready_in  = 1'b1;

        // Reset held: everything reads zero even with a request offered.
        #2 rst_in = 1'b0;
        #1;
        check("rst_ready", 32'(request_ready_out), 32'h0);
        check("rst_rvalid", 32'(response_valid_out), 32'h0);
        check("rst_data", response_data_out, 32'h0);
        check("rst_fault", 32'(response_fault_out), 32'h0);
        check("rst_en", 32'(bram_en_out), 32'h0);
        check("rst_addr", 32'(bram_addr_out), 32'h0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in           = 1'b1;
        request_valid_in = 1'b0;
        #1;
        check("rel_ready", 32'(request_ready_out), 32'h1);

        // Single fetch of 0x10 -> BRAM[4], valid two cycles later.
        drive(1'b1, 32'h0000_0010, 1'b1, 1'b0);
        check("t1_ready", 32'(request_ready_out), 32'h1);
        check("t1_en", 32'(bram_en_out), 32'h1);
        check("t1_addr", 32'(bram_addr_out), 32'h4);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t1_rvalid_c1", 32'(response_valid_out), 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t1_rvalid_c2", 32'(response_valid_out), 32'h1);
        check("t1_data", response_data_out, 32'hDEAD_BEEF);
        check("t1_fault", 32'(response_fault_out), 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t1_rvalid_c3", 32'(response_valid_out), 32'h0);

        // Back-to-back fetches 0x0..0x10 with the core always ready.
        for (int c = 0; c < 7; c++) begin
            drive(c < 5, 32'(4 * c), 1'b1, 1'b0);
            if (c < 5) check("t2_ready", 32'(request_ready_out), 32'h1);
            if (c >= 2) begin
                check("t2_rvalid", 32'(response_valid_out), 32'h1);
                check("t2_data", response_data_out, t2_exp[c-2]);
            end else begin
                check("t2_rvalid_idle", 32'(response_valid_out), 32'h0);
            end
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t2_drained", 32'(response_valid_out), 32'h0);

        // Backpressure: exactly four accepted, then ready drops until the first pop.
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 32'h20 + 32'(4 * c), 1'b0, 1'b0);
            check("t3_ready", 32'(request_ready_out), (c < 4) ? 32'h1 : 32'h0);
            check("t3_rvalid", 32'(response_valid_out), (c >= 2) ? 32'h1 : 32'h0);
            if (c >= 2) check("t3_head", response_data_out, 32'hC0DE_0008);
        end
        for (int c = 6; c < 10; c++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            check("t3_ready_pop", 32'(request_ready_out), (c >= 7) ? 32'h1 : 32'h0);
            check("t3_rvalid_pop", 32'(response_valid_out), 32'h1);
            check("t3_data", response_data_out, 32'hC0DE_0008 + 32'(c - 6));
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t3_drained", 32'(response_valid_out), 32'h0);
        check("t3_ready_end", 32'(request_ready_out), 32'h1);

        // Flush with three outstanding, then a fresh fetch of 0x14 -> BRAM[5].
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 32'h40 + 32'(4 * c), 1'b0, 1'b0);
            check("t4_ready", 32'(request_ready_out), 32'h1);
        end
        drive(1'b1, 32'h50, 1'b0, 1'b1);
        check("t4_flush_ready", 32'(request_ready_out), 32'h0);
        check("t4_flush_en", 32'(bram_en_out), 32'h0);
        drive(1'b1, 32'h14, 1'b1, 1'b0);
        check("t4_post_ready", 32'(request_ready_out), 32'h1);
        check("t4_post_rvalid", 32'(response_valid_out), 32'h0);
        check("t4_post_addr", 32'(bram_addr_out), 32'h5);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t4_rvalid_c1", 32'(response_valid_out), 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t4_rvalid_c2", 32'(response_valid_out), 32'h1);
        check("t4_data", response_data_out, 32'hC0DE_0005);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t4_rvalid_c3", 32'(response_valid_out), 32'h0);

`ifdef INSTRUCTION_MMU_FAULT_EN
        // Misaligned 0x6 faults without touching the BRAM; 0x8 reads BRAM[2].
        drive(1'b1, 32'h0000_0006, 1'b1, 1'b0);
        check("t5_ready", 32'(request_ready_out), 32'h1);
        check("t5_en_fault", 32'(bram_en_out), 32'h0);
        drive(1'b1, 32'h0000_0008, 1'b1, 1'b0);
        check("t5_en_ok", 32'(bram_en_out), 32'h1);
        check("t5_addr_ok", 32'(bram_addr_out), 32'h2);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t5_rvalid_a", 32'(response_valid_out), 32'h1);
        check("t5_fault_a", 32'(response_fault_out), 32'h1);
        check("t5_data_a", response_data_out, 32'h0000_0013);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t5_rvalid_b", 32'(response_valid_out), 32'h1);
        check("t5_fault_b", 32'(response_fault_out), 32'h0);
        check("t5_data_b", response_data_out, 32'hC0DE_0002);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t5_drained", 32'(response_valid_out), 32'h0);
`else
        // Out-of-range, misaligned 0x4009 aliases to BRAM[2] with no fault.
        drive(1'b1, 32'h0000_4009, 1'b1, 1'b0);
        check("t5_en_alias", 32'(bram_en_out), 32'h1);
        check("t5_addr_alias", 32'(bram_addr_out), 32'h2);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t5_rvalid_c1", 32'(response_valid_out), 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t5_rvalid_c2", 32'(response_valid_out), 32'h1);
        check("t5_data_alias", response_data_out, 32'hC0DE_0002);
        check("t5_fault_alias", 32'(response_fault_out), 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t5_drained", 32'(response_valid_out), 32'h0);
`endif

        // Reset mid-burst with two fetches in flight.
        drive(1'b1, 32'h18, 1'b1, 1'b0);
        drive(1'b1, 32'h1C, 1'b1, 1'b0);
        @(negedge clk_in);
        rst_in           = 1'b0;
        request_valid_in = 1'b1;
        #1;
        check("t6_rst_ready", 32'(request_ready_out), 32'h0);
        check("t6_rst_rvalid", 32'(response_valid_out), 32'h0);
        check("t6_rst_data", response_data_out, 32'h0);
        check("t6_rst_fault", 32'(response_fault_out), 32'h0);
        check("t6_rst_en", 32'(bram_en_out), 32'h0);
        check("t6_rst_addr", 32'(bram_addr_out), 32'h0);
        @(negedge clk_in);
        rst_in           = 1'b1;
        request_valid_in = 1'b0;
        #1;
        check("t6_rel_ready", 32'(request_ready_out), 32'h1);
        check("t6_rel_rvalid", 32'(response_valid_out), 32'h0);
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            check("t6_no_resp", 32'(response_valid_out), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
